solver_datapath: RTL and testbench
==================================

// Module: solver_datapath
// PURPOSE
//  Multi-precision fixed-point datapath for Mandelbrot iteration z <- z^2 + c, processed one limb per instruction.
//  Holds c and z in limb banks and runs a 5-stage pipeline: L(load) R(read) M(multiply) X(accumulate) W(write).
//  An external microcoded controller issues one instruction per cycle as the C_* signals. It also flags divergence.
// PARAMETERS
//  LIMB_INDEX_BITS   6  limb address width; each bank holds 2**LIMB_INDEX_BITS limbs
//  LIMB_SIZE_BITS    8  limb width (L)
//  DIVERGENCE_RADIUS 4  magnitude limit on the integer limb of zre/zim
// PORTS
//  clock  in 1  single clock; all state updates on the rising edge
//  reset  in 1  synchronous, active-high
//  C_cre_limb, C_cim_limb  in L  limb data to load into CRE/CIM
//  C_limb_ind  in LIMB_INDEX_BITS  c-bank index: load address and read ports C/D
//  C_zre_ind, C_zim_ind  in LIMB_INDEX_BITS  read-port A/B index; also the write index for ZRE/ZIM
//  C_cre_wr_en, C_cim_wr_en  in 1  load enables
//  C_zre_reg_sel, C_zim_reg_sel  in 2  bank for port A/B: 0=ZRE 1=ZIM 2=CRE 3=CIM
//  C_m1_a_sel, C_m1_b_sel, C_m2_a_sel, C_m2_b_sel  in 2  multiplier operand: 0=A 1=B 2=C 3=D
//  C_op_sel  in 1  0=multiply-accumulate, 1=negate
//  C_zre_partial_sel  in 2  0=zero 1=m1-m2 2=m1 3=port C
//  C_zim_partial_sel  in 1  0=2*m2 1=port D
//  C_zre_acc_sel, C_zim_acc_sel  in 2  accumulator op: 0=hold 1=shift-add 2=clear-load 3=add
//  C_zre_wr_en, C_zim_wr_en  in 1  bank write enables
//  W_diverged  out 1  registered divergence flag
// BEHAVIOUR
//  - Number format: limb 0 is the signed integer part; limb k has weight 2^(-L*k). Two's complement.
//  - Instruction model: all C_* inputs of one cycle form one instruction. Each field is delayed internally to its stage.
//  - L, issue cycle t: CRE[C_limb_ind]<=C_cre_limb if C_cre_wr_en; same for CIM.
//  - R, edge t+1: register A=bank[zre_reg_sel][zre_ind], B=bank[zim_reg_sel][zim_ind], C=CRE[limb_ind], D=CIM[limb_ind].
//  - M, edge t+2: m1=opA*opB and m2=opA*opB, each an unsigned LxL->2L registered product. Sign handling is the controller's job (it uses negate).
//  - X, edge t+3: each accumulator is signed, 2L+4 bits; partial is sign-extended to that width.
//    hold: acc. shift-add: (acc>>>L)+partial. clear-load: partial. add: acc+partial.
//  - Negate mode (op_sel=1): partial is ~A (zre acc) and ~B (zim acc), zero-extended. Clear-load adds +1.
//    Negate runs LSB limb first using shift-add, so the carry propagates to the next limb.
//  - W, edge t+4: if wr_en, ZRE[zre_ind]<=zre_acc[L-1:0] (ZIM likewise), using the index travelling with the instruction.
//  - Issue-to-bank latency is 4 cycles. There is no forwarding: reading a limb still in flight returns the old value.
//  - After the last write, the controller must wait 4 cycles before reading that limb.
//  - Simultaneous CRE load and R read of the same address returns the old value.
//  - Reset: all banks, accumulators, pipeline registers and W_diverged go to 0. In-flight writes are discarded.
//    Reset mid-operation therefore produces no bank writes.
// CONFIGURATION
//  SOLVER_DATAPATH_DIVERGE_EN defined:
//    W_diverged is set, one cycle after the W write, when a limb-0 write to ZRE or ZIM has |signed value| >= DIVERGENCE_RADIUS.
//    The flag is sticky. It is cleared by reset or by any C_cre_wr_en.
//  Not defined: W_diverged is tied to 0 and the compare logic is omitted.
// STRUCTURE
//  - Package solver_pkg holds:
//    bank codes (ZRE/ZIM/CRE/CIM), operand codes (A/B/C/D), partial-select codes,
//    acc ops (HOLD/SHIFT/CLEAR/ADD), op codes (MAC/NEG), and a typedef for the stage control bundle.
//  - One sub-module, limb_bank: 2**LIMB_INDEX_BITS x L flop array, sync write, async read, sync reset.
//    Instantiated four times.
//  - Bank arrays are reachable hierarchically as cre_mem/cim_mem/zre_mem/zim_mem for verification.
// TESTING
//  - Load CRE[0]=0x00, CRE[1]=0x80, CIM[0]=0x01, CIM[1]=0x80 -> banks hold these values next cycle; W_diverged=0.
//  - Copy: limb_ind=1, zre_ind=1, zre_partial 3, acc clear-load, zre_wr_en -> zre_mem[1]=0x80 four cycles later.
//  - Square: ZRE[1]=0x80, m1=A*A, partial 2, clear-load with write -> zre_mem[1]=0x00.
//    Next instruction: partial 0, shift-add, write zre_ind=0 -> zre_mem[0]=0x40.
//  - Negate: ZRE[1]=0x00, ZRE[0]=0x01; op_sel=1, limb1 clear-load then limb0 shift-add -> ZRE[1]=0x00, ZRE[0]=0xFF.
//  - Diverge (macro on): CRE[0]=0x04 copied to ZRE[0] -> W_diverged=1. Next CRE load -> 0. Macro off -> always 0.
//  - Reset asserted 2 cycles after a write instruction -> no bank write; all banks read 0.

Source files
------------

// File: rtl/solver_pkg.sv
// Shared encodings and stage control bundles for the Mandelbrot limb datapath.
package solver_pkg;

  typedef enum logic [1:0] {BankZre, BankZim, BankCre, BankCim} bank_e;
  typedef enum logic [1:0] {OperA, OperB, OperC, OperD} operand_e;
  typedef enum logic [1:0] {ZrePartZero, ZrePartDiff, ZrePartM1, ZrePartC} zre_part_e;
  typedef enum logic {ZimPartM2x2, ZimPartD} zim_part_e;
  typedef enum logic [1:0] {AccHold, AccShift, AccClear, AccAdd} acc_op_e;
  typedef enum logic {OpMac, OpNeg} op_e;

  // Each stage strips off the fields it consumes and hands the rest onward.
  typedef struct packed {
    op_e       op;
    zre_part_e zre_part;
    zim_part_e zim_part;
    acc_op_e   zre_acc;
    acc_op_e   zim_acc;
    logic      zre_wr_en;
    logic      zim_wr_en;
  } x_ctrl_t;

  typedef struct packed {
    operand_e m1_a;
    operand_e m1_b;
    operand_e m2_a;
    operand_e m2_b;
    x_ctrl_t  x;
  } m_ctrl_t;

  typedef struct packed {
    bank_e   zre_reg_sel;
    bank_e   zim_reg_sel;
    m_ctrl_t m;
  } ctrl_t;

endpackage

// File: rtl/limb_bank.sv
// Flop array of limbs: synchronous write and reset, whole array visible for async reads.
module limb_bank #(
  parameter int unsigned IndexBits = 6,
  parameter int unsigned Width     = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [IndexBits-1:0] wr_idx_i,
  input  logic [Width-1:0]     wr_data_i,
  output logic [Width-1:0]     mem_o [2**IndexBits]
);

  localparam int unsigned Depth = 2 ** IndexBits;

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign mem_o = mem_q;

endmodule

// File: rtl/solver_datapath.sv
// Five-stage (L/R/M/X/W) limb-serial datapath for z <- z^2 + c.
// Optional divergence flag enabled by defining SOLVER_DATAPATH_DIVERGE_EN.
module solver_datapath
  import solver_pkg::*;
#(
  parameter int unsigned LIMB_INDEX_BITS   = 6,
  parameter int unsigned LIMB_SIZE_BITS    = 8,
  parameter int unsigned DIVERGENCE_RADIUS = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [LIMB_SIZE_BITS-1:0]  C_cre_limb,
  input  logic [LIMB_SIZE_BITS-1:0]  C_cim_limb,
  input  logic [LIMB_INDEX_BITS-1:0] C_limb_ind,
  input  logic [LIMB_INDEX_BITS-1:0] C_zre_ind,
  input  logic [LIMB_INDEX_BITS-1:0] C_zim_ind,
  input  logic                       C_cre_wr_en,
  input  logic                       C_cim_wr_en,
  input  logic [1:0]                 C_zre_reg_sel,
  input  logic [1:0]                 C_zim_reg_sel,
  input  logic [1:0]                 C_m1_a_sel,
  input  logic [1:0]                 C_m1_b_sel,
  input  logic [1:0]                 C_m2_a_sel,
  input  logic [1:0]                 C_m2_b_sel,
  input  logic                       C_op_sel,
  input  logic [1:0]                 C_zre_partial_sel,
  input  logic                       C_zim_partial_sel,
  input  logic [1:0]                 C_zre_acc_sel,
  input  logic [1:0]                 C_zim_acc_sel,
  input  logic                       C_zre_wr_en,
  input  logic                       C_zim_wr_en,
  output logic                       W_diverged
);

  localparam int unsigned L     = LIMB_SIZE_BITS;
  localparam int unsigned AccW  = 2 * L + 4;
  localparam int unsigned Depth = 2 ** LIMB_INDEX_BITS;

  typedef logic [LIMB_INDEX_BITS-1:0] idx_t;
  typedef logic [L-1:0]               limb_t;
  typedef logic [2*L-1:0]             prod_t;
  typedef logic signed [AccW-1:0]     acc_t;

  limb_t cre_mem [Depth];
  limb_t cim_mem [Depth];
  limb_t zre_mem [Depth];
  limb_t zim_mem [Depth];

  ctrl_t   ctrl_in, r_ctrl_q;
  m_ctrl_t m_ctrl_q;
  x_ctrl_t x_ctrl_q;
  logic    zre_wr_q, zim_wr_q;

  idx_t [4:1] zre_ind_q;
  idx_t [4:1] zim_ind_q;
  idx_t       limb_ind_q;

  limb_t rd_a, rd_b;
  limb_t a_q, b_q, c_q, d_q;
  limb_t a_x_q, b_x_q, c_x_q, d_x_q;
  prod_t m1_q, m2_q, m_diff;
  acc_t  zre_part, zim_part, zre_acc_q, zim_acc_q;

  assign ctrl_in = '{
    zre_reg_sel: bank_e'(C_zre_reg_sel),
    zim_reg_sel: bank_e'(C_zim_reg_sel),
    m: '{
      m1_a: operand_e'(C_m1_a_sel),
      m1_b: operand_e'(C_m1_b_sel),
      m2_a: operand_e'(C_m2_a_sel),
      m2_b: operand_e'(C_m2_b_sel),
      x: '{
        op:        op_e'(C_op_sel),
        zre_part:  zre_part_e'(C_zre_partial_sel),
        zim_part:  zim_part_e'(C_zim_partial_sel),
        zre_acc:   acc_op_e'(C_zre_acc_sel),
        zim_acc:   acc_op_e'(C_zim_acc_sel),
        zre_wr_en: C_zre_wr_en,
        zim_wr_en: C_zim_wr_en
      }
    }
  };

  limb_bank #(.IndexBits(LIMB_INDEX_BITS), .Width(L)) u_cre (
    .clk_i(clock), .rst_i(reset), .wr_en_i(C_cre_wr_en), .wr_idx_i(C_limb_ind),
    .wr_data_i(C_cre_limb), .mem_o(cre_mem)
  );
  limb_bank #(.IndexBits(LIMB_INDEX_BITS), .Width(L)) u_cim (
    .clk_i(clock), .rst_i(reset), .wr_en_i(C_cim_wr_en), .wr_idx_i(C_limb_ind),
    .wr_data_i(C_cim_limb), .mem_o(cim_mem)
  );
  limb_bank #(.IndexBits(LIMB_INDEX_BITS), .Width(L)) u_zre (
    .clk_i(clock), .rst_i(reset), .wr_en_i(zre_wr_q), .wr_idx_i(zre_ind_q[4]),
    .wr_data_i(zre_acc_q[L-1:0]), .mem_o(zre_mem)
  );
  limb_bank #(.IndexBits(LIMB_INDEX_BITS), .Width(L)) u_zim (
    .clk_i(clock), .rst_i(reset), .wr_en_i(zim_wr_q), .wr_idx_i(zim_ind_q[4]),
    .wr_data_i(zim_acc_q[L-1:0]), .mem_o(zim_mem)
  );

  function automatic limb_t pick_op(operand_e sel, limb_t a, limb_t b, limb_t c, limb_t d);
    limb_t r;
    r = a;
    unique case (sel)
      OperA: r = a;
      OperB: r = b;
      OperC: r = c;
      OperD: r = d;
    endcase
    return r;
  endfunction

  function automatic acc_t acc_step(acc_op_e op, acc_t acc, acc_t part, logic inc);
    acc_t r;
    r = acc;
    unique case (op)
      AccHold:  r = acc;
      AccShift: r = (acc >>> L) + part;
      AccClear: r = part + {{(AccW-1){1'b0}}, inc};
      AccAdd:   r = acc + part;
    endcase
    return r;
  endfunction

  // Reads see bank contents before this edge's writes, so in-flight limbs return old data.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    unique case (r_ctrl_q.zre_reg_sel)
      BankZre: rd_a = zre_mem[zre_ind_q[1]];
      BankZim: rd_a = zim_mem[zre_ind_q[1]];
      BankCre: rd_a = cre_mem[zre_ind_q[1]];
      BankCim: rd_a = cim_mem[zre_ind_q[1]];
    endcase
    unique case (r_ctrl_q.zim_reg_sel)
      BankZre: rd_b = zre_mem[zim_ind_q[1]];
      BankZim: rd_b = zim_mem[zim_ind_q[1]];
      BankCre: rd_b = cre_mem[zim_ind_q[1]];
      BankCim: rd_b = cim_mem[zim_ind_q[1]];
    endcase
  end

  assign m_diff = m1_q - m2_q;

  always_comb begin
    zre_part = '0;
    zim_part = '0;
    if (x_ctrl_q.op == OpNeg) begin
      zre_part = {{(AccW-L){1'b0}}, ~a_x_q};
      zim_part = {{(AccW-L){1'b0}}, ~b_x_q};
    end else begin
      unique case (x_ctrl_q.zre_part)
        ZrePartZero: zre_part = '0;
        ZrePartDiff: zre_part = {{(AccW-2*L){m_diff[2*L-1]}}, m_diff};
        ZrePartM1:   zre_part = {{(AccW-2*L){m1_q[2*L-1]}}, m1_q};
        ZrePartC:    zre_part = {{(AccW-L){c_x_q[L-1]}}, c_x_q};
      endcase
      unique case (x_ctrl_q.zim_part)
        ZimPartM2x2: zim_part = {{(AccW-2*L-1){m2_q[2*L-1]}}, m2_q, 1'b0};
        ZimPartD:    zim_part = {{(AccW-L){d_x_q[L-1]}}, d_x_q};
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ctrl_q   <= '0;
      m_ctrl_q   <= '0;
      x_ctrl_q   <= '0;
      zre_wr_q   <= 1'b0;
      zim_wr_q   <= 1'b0;
      zre_ind_q  <= '0;
      zim_ind_q  <= '0;
      limb_ind_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      d_q        <= '0;
      a_x_q      <= '0;
      b_x_q      <= '0;
      c_x_q      <= '0;
      d_x_q      <= '0;
      m1_q       <= '0;
      m2_q       <= '0;
      zre_acc_q  <= '0;
      zim_acc_q  <= '0;
    end else begin
      r_ctrl_q   <= ctrl_in;
      m_ctrl_q   <= r_ctrl_q.m;
      x_ctrl_q   <= m_ctrl_q.x;
      zre_wr_q   <= x_ctrl_q.zre_wr_en;
      zim_wr_q   <= x_ctrl_q.zim_wr_en;
      zre_ind_q  <= {zre_ind_q[3:1], C_zre_ind};
      zim_ind_q  <= {zim_ind_q[3:1], C_zim_ind};
      limb_ind_q <= C_limb_ind;
      // R
      a_q <= rd_a;
      b_q <= rd_b;
      c_q <= cre_mem[limb_ind_q];
      d_q <= cim_mem[limb_ind_q];
      // M
      m1_q  <= prod_t'(pick_op(m_ctrl_q.m1_a, a_q, b_q, c_q, d_q)) *
               prod_t'(pick_op(m_ctrl_q.m1_b, a_q, b_q, c_q, d_q));
      m2_q  <= prod_t'(pick_op(m_ctrl_q.m2_a, a_q, b_q, c_q, d_q)) *
               prod_t'(pick_op(m_ctrl_q.m2_b, a_q, b_q, c_q, d_q));
      a_x_q <= a_q;
      b_x_q <= b_q;
      c_x_q <= c_q;
      d_x_q <= d_q;
      // X: negate's +1 only enters on the first (clear-load) limb
      zre_acc_q <= acc_step(x_ctrl_q.zre_acc, zre_acc_q, zre_part, x_ctrl_q.op == OpNeg);
      zim_acc_q <= acc_step(x_ctrl_q.zim_acc, zim_acc_q, zim_part, x_ctrl_q.op == OpNeg);
    end
  end

`ifdef SOLVER_DATAPATH_DIVERGE_EN
  localparam int Radius = int'(DIVERGENCE_RADIUS);

  function automatic logic too_big(limb_t v);
    int s;
    s = int'($signed(v));
    return (s >= Radius) || (s <= -Radius);
  endfunction

  logic div_hit, div_pend_q, diverged_q;

  assign div_hit = (zre_wr_q && (zre_ind_q[4] == '0) && too_big(zre_acc_q[L-1:0])) ||
                   (zim_wr_q && (zim_ind_q[4] == '0) && too_big(zim_acc_q[L-1:0]));

  // A new c point starts a fresh orbit, so a load clears the sticky flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_pend_q <= 1'b0;
      diverged_q <= 1'b0;
    end else begin
      div_pend_q <= div_hit;
      if (C_cre_wr_en) begin
        diverged_q <= 1'b0;
      end else if (div_pend_q) begin
        diverged_q <= 1'b1;
      end
    end
  end

  assign W_diverged = diverged_q;
`else
  assign W_diverged = 1'b0;
`endif

endmodule

// File: tb/tb_solver_datapath.sv
// Directed self-checking bench for solver_datapath (follows SOLVER_DATAPATH_DIVERGE_EN).
module tb_solver_datapath;

`ifdef SOLVER_DATAPATH_DIVERGE_EN
  localparam logic [7:0] DivOn = 8'd1;
`else
  localparam logic [7:0] DivOn = 8'd0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] C_cre_limb, C_cim_limb;
  logic [5:0] C_limb_ind, C_zre_ind, C_zim_ind;
  logic       C_cre_wr_en, C_cim_wr_en;
  logic [1:0] C_zre_reg_sel, C_zim_reg_sel;
  logic [1:0] C_m1_a_sel, C_m1_b_sel, C_m2_a_sel, C_m2_b_sel;
  logic       C_op_sel;
  logic [1:0] C_zre_partial_sel;
  logic       C_zim_partial_sel;
  logic [1:0] C_zre_acc_sel, C_zim_acc_sel;
  logic       C_zre_wr_en, C_zim_wr_en;
  logic       W_diverged;

  int checks = 0;
  int failures = 0;

  solver_datapath dut (
    .clock(clock), .reset(reset),
    .C_cre_limb(C_cre_limb), .C_cim_limb(C_cim_limb),
    .C_limb_ind(C_limb_ind), .C_zre_ind(C_zre_ind), .C_zim_ind(C_zim_ind),
    .C_cre_wr_en(C_cre_wr_en), .C_cim_wr_en(C_cim_wr_en),
    .C_zre_reg_sel(C_zre_reg_sel), .C_zim_reg_sel(C_zim_reg_sel),
    .C_m1_a_sel(C_m1_a_sel), .C_m1_b_sel(C_m1_b_sel),
    .C_m2_a_sel(C_m2_a_sel), .C_m2_b_sel(C_m2_b_sel),
    .C_op_sel(C_op_sel),
    .C_zre_partial_sel(C_zre_partial_sel), .C_zim_partial_sel(C_zim_partial_sel),
    .C_zre_acc_sel(C_zre_acc_sel), .C_zim_acc_sel(C_zim_acc_sel),
    .C_zre_wr_en(C_zre_wr_en), .C_zim_wr_en(C_zim_wr_en),
    .W_diverged(W_diverged)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    C_cre_limb = '0; C_cim_limb = '0;
    C_limb_ind = '0; C_zre_ind = '0; C_zim_ind = '0;
    C_cre_wr_en = 0; C_cim_wr_en = 0;
    C_zre_reg_sel = 2'd0; C_zim_reg_sel = 2'd0;
    C_m1_a_sel = 2'd0; C_m1_b_sel = 2'd0; C_m2_a_sel = 2'd0; C_m2_b_sel = 2'd0;
    C_op_sel = 0;
    C_zre_partial_sel = 2'd0; C_zim_partial_sel = 0;
    C_zre_acc_sel = 2'd0; C_zim_acc_sel = 2'd0;
    C_zre_wr_en = 0; C_zim_wr_en = 0;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Copy CRE[limb] into ZRE[zre_ind] via port C and clear-load.
  task automatic copy_c(input logic [5:0] limb, input logic [5:0] zi);
    idle();
    C_limb_ind = limb; C_zre_ind = zi;
    C_zre_partial_sel = 2'd3; C_zre_acc_sel = 2'd2; C_zre_wr_en = 1;
    step();
    idle();
  endtask

  task automatic load_cre(input logic [5:0] limb, input logic [7:0] v);
    idle();
    C_limb_ind = limb; C_cre_limb = v; C_cre_wr_en = 1;
    step();
    idle();
  endtask

  initial begin
    idle();
    reset = 1;
    step(); step();
    reset = 0;
    check("rst_zre0", dut.zre_mem[0], 8'h00);
    check("rst_cre1", dut.cre_mem[1], 8'h00);
    check("rst_div", {7'd0, W_diverged}, 8'h00);

    // Load c limbs
    C_limb_ind = 0; C_cre_limb = 8'h00; C_cim_limb = 8'h01; C_cre_wr_en = 1; C_cim_wr_en = 1;
    step();
    C_limb_ind = 1; C_cre_limb = 8'h80; C_cim_limb = 8'h80;
    step();
    idle();
    check("load_cre0", dut.cre_mem[0], 8'h00);
    check("load_cre1", dut.cre_mem[1], 8'h80);
    check("load_cim0", dut.cim_mem[0], 8'h01);
    check("load_cim1", dut.cim_mem[1], 8'h80);
    check("load_div", {7'd0, W_diverged}, 8'h00);

    // Copy CRE[1] -> ZRE[1] and CIM[1] -> ZIM[1]
    C_limb_ind = 1; C_zre_ind = 1; C_zim_ind = 1;
    C_zre_partial_sel = 2'd3; C_zre_acc_sel = 2'd2; C_zre_wr_en = 1;
    C_zim_partial_sel = 1; C_zim_acc_sel = 2'd2; C_zim_wr_en = 1;
    step();
    idle();
    repeat (3) step();
    check("copy_latency", dut.zre_mem[1], 8'h00);
    step();
    check("copy_zre1", dut.zre_mem[1], 8'h80);
    check("copy_zim1", dut.zim_mem[1], 8'h80);

    // Square ZRE[1]; zim path: 2*(CRE[1]*CIM[0]) then shift-add CIM[0]
    C_zre_ind = 1; C_zre_partial_sel = 2'd2; C_zre_acc_sel = 2'd2; C_zre_wr_en = 1;
    C_zim_reg_sel = 2'd2; C_zim_ind = 1; C_limb_ind = 0;
    C_m2_a_sel = 2'd1; C_m2_b_sel = 2'd3;
    C_zim_partial_sel = 0; C_zim_acc_sel = 2'd2; C_zim_wr_en = 1;
    step();
    idle();
    C_zre_ind = 0; C_zre_partial_sel = 2'd0; C_zre_acc_sel = 2'd1; C_zre_wr_en = 1;
    C_zim_ind = 0; C_limb_ind = 0; C_zim_partial_sel = 1; C_zim_acc_sel = 2'd1; C_zim_wr_en = 1;
    step();
    idle();
    repeat (4) step();
    check("sq_zre1", dut.zre_mem[1], 8'h00);
    check("sq_zre0", dut.zre_mem[0], 8'h40);
    check("m2_zim1", dut.zim_mem[1], 8'h00);
    check("m2_zim0", dut.zim_mem[0], 8'h02);

    // Negate ZRE (0x40.00) and ZIM (0x02.00), LSB limb first
    C_op_sel = 1; C_zim_reg_sel = 2'd1; C_zre_ind = 1; C_zim_ind = 1;
    C_zre_acc_sel = 2'd2; C_zim_acc_sel = 2'd2; C_zre_wr_en = 1; C_zim_wr_en = 1;
    step();
    idle();
    C_op_sel = 1; C_zim_reg_sel = 2'd1; C_zre_ind = 0; C_zim_ind = 0;
    C_zre_acc_sel = 2'd1; C_zim_acc_sel = 2'd1; C_zre_wr_en = 1; C_zim_wr_en = 1;
    step();
    idle();
    repeat (4) step();
    check("neg_zre1", dut.zre_mem[1], 8'h00);
    check("neg_zre0", dut.zre_mem[0], 8'hC0);
    check("neg_zim1", dut.zim_mem[1], 8'h00);
    check("neg_zim0", dut.zim_mem[0], 8'hFE);

    // Divergence: load clears, write of 4 sets one cycle after the write
    load_cre(0, 8'h04);
    check("div_cleared", {7'd0, W_diverged}, 8'h00);
    copy_c(0, 0);
    repeat (4) step();
    check("div_copy_zre0", dut.zre_mem[0], 8'h04);
    check("div_early", {7'd0, W_diverged}, 8'h00);
    step();
    check("div_set", {7'd0, W_diverged}, DivOn);
    load_cre(0, 8'h03);
    check("div_load_clr", {7'd0, W_diverged}, 8'h00);
    copy_c(0, 0);
    repeat (6) step();
    check("div_below", {7'd0, W_diverged}, 8'h00);
    load_cre(0, 8'hFC);
    copy_c(0, 0);
    repeat (5) step();
    check("div_neg4", {7'd0, W_diverged}, DivOn);

    // Reset two cycles after a write instruction discards it
    copy_c(0, 1);
    step();
    reset = 1;
    step(); step();
    reset = 0;
    repeat (4) step();
    check("rst_mid_zre1", dut.zre_mem[1], 8'h00);
    check("rst_mid_zre0", dut.zre_mem[0], 8'h00);
    check("rst_mid_cre0", dut.cre_mem[0], 8'h00);
    check("rst_mid_cim1", dut.cim_mem[1], 8'h00);
    check("rst_mid_zim0", dut.zim_mem[0], 8'h00);
    check("rst_mid_div", {7'd0, W_diverged}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
